sram_uart_dumper: RTL and testbench
===================================

// Module: sram_uart_dumper
// PURPOSE
//  Reads a word-organised SRAM from address 0 to DEPTH-1 and streams it out through a uart_tx byte port.
//  Complement of the UART memory loader: a host captures the dump for readback/verification of loaded images.
//  Frame: SYNC_BYTE, then DEPTH*4 data bytes (byte lane 0 first per word), then optional 8-bit checksum.
//  Sits beside the loader; the top-level owns the SRAM port mux and grants it while busy=1.
// PARAMETERS
//  ADDR_W      10     SRAM word-address width
//  DEPTH       1024   words dumped per frame (1..2**ADDR_W)
//  SYNC_BYTE   8'h53  frame header byte ("S")
//  CHECKSUM_EN 1      1: append sum-mod-256 of all data bytes; 0: no trailer
// PORTS
//  clk           in   1       clock
//  nRST          in   1       reset; synchronous, active-low
//  start         in   1       1-cycle request to begin a dump; ignored while busy
//  busy          out  1       high from the cycle after start accepted until done
//  done          out  1       1-cycle pulse after the last frame byte completes on the UART
//  sram_rd_en    out  1       SRAM read strobe
//  sram_addr     out  ADDR_W  SRAM word address
//  sram_rdata    in   32      SRAM read data, valid the cycle after sram_rd_en
//  tx_start      out  1       uart_tx launch strobe
//  tx_data       out  8       byte to send, valid while tx_start=1
//  tx_busy       in   1       uart_tx busy; rises the cycle after tx_start is sampled, falls after the stop bit
// BEHAVIOUR
//  Reset (nRST=0 at edge): state IDLE; busy,done,sram_rd_en,tx_start=0; sram_addr,tx_data=0; word ptr,
//   byte idx, checksum cleared. Mid-frame reset abandons the frame; a byte already in uart_tx is not aborted.
//  FSM: IDLE -> SYNC_ISSUE -> SYNC_WAIT -> RD_REQ -> RD_CAP -> BYTE_ISSUE -> BYTE_WAIT
//   -> (BYTE_ISSUE | RD_REQ | CK_ISSUE | FIN) ; CK_ISSUE -> CK_WAIT -> FIN ; FIN -> IDLE.
//  IDLE: on start=1 -> SYNC_ISSUE, busy<=1, ptr<=0, checksum<=0.
//  *_ISSUE: when tx_busy=0, drive tx_start=1 for exactly 1 cycle with tx_data, then go to *_WAIT.
//   If tx_busy=1, hold tx_start=0 and wait.
//  *_WAIT: first cycle is unconditional (covers tx_busy rise latency); then leave when tx_busy=0.
//  RD_REQ: sram_rd_en=1 for exactly 1 cycle, sram_addr=ptr. RD_CAP: latch sram_rdata into word reg, idx<=0.
//   sram_addr holds ptr through RD_CAP; sram_rd_en=0 in all other states.
//  BYTE_ISSUE sends word[8*idx+7:8*idx] and adds it to checksum (8-bit, wraps mod 256).
//  BYTE_WAIT exit: idx<3 -> idx+1, BYTE_ISSUE; idx==3 and ptr<DEPTH-1 -> ptr+1, RD_REQ;
//   idx==3 and ptr==DEPTH-1 -> CK_ISSUE if CHECKSUM_EN, else FIN. ptr never wraps within a frame.
//  CK_ISSUE sends the final checksum (SYNC_BYTE excluded).
//  FIN: done=1 for 1 cycle, busy<=0, sram_addr<=0 -> IDLE. A start in the same cycle as done is ignored.
//  tx_start is never asserted on consecutive cycles. Each word is read exactly once.
//  Total bytes per frame: 1 + 4*DEPTH + CHECKSUM_EN.
//  Latency: start -> first tx_start = 2 cycles when tx_busy=0.
// TESTING (bench: DEPTH=4, behavioural SRAM 1-cycle read, uart_tx model busy 10 cycles/byte)
//  1 SRAM={32'h44332211,32'h88776655,32'hCCBBAA99,32'h00FFEEDD}, start -> tx bytes 53,11,22,33,44,55,66,77,88,
//    99,AA,BB,CC,DD,EE,FF,00,F8 (sum mod 256 = F8); done 1 pulse; busy low after.
//  2 Same data, CHECKSUM_EN=0 -> 17 bytes ending 00; no checksum byte; done pulses once.
//  3 Hold tx_busy=1 externally for 50 cycles at start -> no tx_start until tx_busy falls; output unchanged.
//  4 Pulse start again mid-frame and in the done cycle -> ignored; exactly one frame emitted.
//  5 nRST low for 1 cycle after 6th byte -> next cycle busy=0, tx_start=0, sram_rd_en=0;
//    new start emits full frame from 53.
//  6 Check sram_rd_en asserted exactly 4 times, addresses 0,1,2,3; never overlapping tx_start.

Source files
------------

// File: rtl/sram_uart_dumper_if.sv
// Purpose: SRAM read port and uart_tx byte port used by the SRAM dumper.
// Ports (signals):
//   sram_rd_en   master->slave  SRAM read strobe
//   sram_addr    master->slave  SRAM word address (ADDR_W bits)
//   sram_rdata   slave->master  SRAM read data, valid the cycle after sram_rd_en
//   tx_start     master->slave  uart_tx launch strobe
//   tx_data      master->slave  byte to send, valid while tx_start=1
//   tx_busy      slave->master  uart_tx busy
interface sram_uart_dumper_if #(
   parameter int unsigned ADDR_W = 10
) ();
   logic              sram_rd_en;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_rdata;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;

   modport master (
      output sram_rd_en, sram_addr, tx_start, tx_data,
      input  sram_rdata, tx_busy
   );

   modport slave (
      input  sram_rd_en, sram_addr, tx_start, tx_data,
      output sram_rdata, tx_busy
   );
endinterface

// File: rtl/sram_uart_dumper.sv
// Purpose: reads SRAM words 0..DEPTH-1 and streams them to a uart_tx byte port
//          as SYNC_BYTE, DEPTH*4 data bytes (lane 0 first), optional checksum.
// Ports:
//   clk       clock
//   nRST      synchronous active-low reset
//   start_i   1-cycle dump request, ignored while busy
//   busy_o    high from the cycle after start is accepted until done
//   done_o    1-cycle pulse once the last frame byte has left the UART
//   bus       master side of sram_uart_dumper_if (SRAM read + uart_tx)
module sram_uart_dumper #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DEPTH       = 1024,
   parameter logic [7:0]  SYNC_BYTE   = 8'h53,
   parameter bit          CHECKSUM_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 nRST,
   input  logic                 start_i,
   output logic                 busy_o,
   output logic                 done_o,
   sram_uart_dumper_if.master   bus
);

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SYNC_ISSUE,
      S_SYNC_WAIT,
      S_RD_REQ,
      S_RD_CAP,
      S_BYTE_ISSUE,
      S_BYTE_WAIT,
      S_CK_ISSUE,
      S_CK_WAIT,
      S_FIN
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [1:0]        idx_q;
   logic [31:0]       word_q;
   logic [7:0]        csum_q;
   logic              wait_first_q;
   logic              busy_q;
   logic              done_q;
   logic              rd_en_q;
   logic [ADDR_W-1:0] addr_q;
   logic              tx_start_q;
   logic [7:0]        tx_data_q;

   // Byte lane of the captured word selected by idx
   logic [7:0] cur_byte_c;
   assign cur_byte_c = word_q[{idx_q, 3'b000} +: 8];

   // A wait state may exit only after its first cycle (tx_busy rises one cycle
   // after tx_start is sampled) and once the UART reports idle.
   logic wait_exit_c;
   assign wait_exit_c = !wait_first_q && !bus.tx_busy;

   // Frame sequencer; all outputs are registered. sram_rd_en is raised on the
   // transition into RD_REQ so the strobe coincides with that state and the
   // data is ready in RD_CAP.
   always_ff @(posedge clk) begin
      if (!nRST) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         idx_q        <= '0;
         word_q       <= '0;
         csum_q       <= '0;
         wait_first_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         rd_en_q      <= 1'b0;
         addr_q       <= '0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= '0;
      end else begin
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         tx_start_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_SYNC_ISSUE;
                  busy_q  <= 1'b1;
                  ptr_q   <= '0;
                  csum_q  <= '0;
               end
            end

            S_SYNC_ISSUE: begin
               if (!bus.tx_busy) begin
                  tx_start_q   <= 1'b1;
                  tx_data_q    <= SYNC_BYTE;
                  wait_first_q <= 1'b1;
                  state_q      <= S_SYNC_WAIT;
               end
            end

            S_SYNC_WAIT: begin
               wait_first_q <= 1'b0;
               if (wait_exit_c) begin
                  rd_en_q <= 1'b1;
                  addr_q  <= ptr_q;
                  state_q <= S_RD_REQ;
               end
            end

            S_RD_REQ: begin
               state_q <= S_RD_CAP;
            end

            S_RD_CAP: begin
               word_q  <= bus.sram_rdata;
               idx_q   <= '0;
               state_q <= S_BYTE_ISSUE;
            end

            S_BYTE_ISSUE: begin
               if (!bus.tx_busy) begin
                  tx_start_q   <= 1'b1;
                  tx_data_q    <= cur_byte_c;
                  csum_q       <= csum_q + cur_byte_c;
                  wait_first_q <= 1'b1;
                  state_q      <= S_BYTE_WAIT;
               end
            end

            S_BYTE_WAIT: begin
               wait_first_q <= 1'b0;
               if (wait_exit_c) begin
                  if (idx_q != 2'd3) begin
                     idx_q   <= idx_q + 2'd1;
                     state_q <= S_BYTE_ISSUE;
                  end else if (ptr_q != LAST_PTR) begin
                     ptr_q   <= ptr_q + ADDR_W'(1);
                     rd_en_q <= 1'b1;
                     addr_q  <= ptr_q + ADDR_W'(1);
                     state_q <= S_RD_REQ;
                  end else if (CHECKSUM_EN) begin
                     state_q <= S_CK_ISSUE;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_FIN;
                  end
               end
            end

            S_CK_ISSUE: begin
               if (!bus.tx_busy) begin
                  tx_start_q   <= 1'b1;
                  tx_data_q    <= csum_q;
                  wait_first_q <= 1'b1;
                  state_q      <= S_CK_WAIT;
               end
            end

            S_CK_WAIT: begin
               wait_first_q <= 1'b0;
               if (wait_exit_c) begin
                  done_q  <= 1'b1;
                  state_q <= S_FIN;
               end
            end

            S_FIN: begin
               busy_q  <= 1'b0;
               addr_q  <= '0;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign bus.sram_rd_en = rd_en_q;
   assign bus.sram_addr  = addr_q;
   assign bus.tx_start   = tx_start_q;
   assign bus.tx_data    = tx_data_q;

endmodule

// File: tb/tb_sram_uart_dumper.sv
// Purpose: randomized self-checking bench for sram_uart_dumper. Two DUTs run
//          in lockstep on the same SRAM image: index 0 with checksum, index 1
//          without. Captured UART bytes and SRAM reads are compared against a
//          frame built directly from the SRAM contents.
module tb_sram_uart_dumper;

   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned DEPTH     = 4;
   localparam int          UART_BUSY = 10;
   localparam int          LIMIT     = 3000;

   logic       clk      = 1'b0;
   logic       nRST     = 1'b0;
   logic [1:0] start_v  = 2'b00;
   logic       ext_busy = 1'b0;

   logic              busy_w     [2];
   logic              done_w     [2];
   logic              rd_en_w    [2];
   logic [ADDR_W-1:0] addr_w     [2];
   logic              tx_start_w [2];
   logic [7:0]        tx_data_w  [2];
   logic [31:0]       rdata_r    [2] = '{32'h0, 32'h0};
   int                ucnt       [2] = '{0, 0};

   logic [31:0] mem [DEPTH];

   logic [7:0]        cap     [2][512];
   logic [ADDR_W-1:0] rda     [2][256];
   int                cap_n   [2] = '{0, 0};
   int                rd_n    [2] = '{0, 0};
   int                done_n  [2] = '{0, 0};
   int                viol    [2] = '{0, 0};
   logic              prev_tx [2] = '{1'b0, 1'b0};

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      sram_uart_dumper_if #(.ADDR_W(ADDR_W)) bus ();

      sram_uart_dumper #(
         .ADDR_W      (ADDR_W),
         .DEPTH       (DEPTH),
         .SYNC_BYTE   (8'h53),
         .CHECKSUM_EN (1'(g == 0))
      ) u_dut (
         .clk     (clk),
         .nRST    (nRST),
         .start_i (start_v[g]),
         .busy_o  (busy_w[g]),
         .done_o  (done_w[g]),
         .bus     (bus)
      );

      assign rd_en_w[g]     = bus.sram_rd_en;
      assign addr_w[g]      = bus.sram_addr;
      assign tx_start_w[g]  = bus.tx_start;
      assign tx_data_w[g]   = bus.tx_data;
      assign bus.sram_rdata = rdata_r[g];
      assign bus.tx_busy    = ext_busy | (ucnt[g] != 0);
   end

   // SRAM with 1-cycle read, uart_tx busy for UART_BUSY cycles per byte
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (rd_en_w[g]) rdata_r[g] <= mem[addr_w[g][1:0]];
         if (ucnt[g] != 0) ucnt[g] <= ucnt[g] - 1;
         else if (tx_start_w[g]) ucnt[g] <= UART_BUSY;
      end
   end

   // Monitors: capture bytes, reads and done pulses; count protocol violations
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (tx_start_w[g]) begin
            if (cap_n[g] < 512) cap[g][cap_n[g]] <= tx_data_w[g];
            cap_n[g] <= cap_n[g] + 1;
            if (prev_tx[g] || rd_en_w[g]) viol[g] <= viol[g] + 1;
         end
         prev_tx[g] <= tx_start_w[g];
         if (rd_en_w[g]) begin
            if (rd_n[g] < 256) rda[g][rd_n[g]] <= addr_w[g];
            rd_n[g] <= rd_n[g] + 1;
         end
         if (done_w[g]) done_n[g] <= done_n[g] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference frame: sync, every SRAM byte lane-0 first, then sum mod 256
   task automatic check_frame(input string tag, input int g, input int bc, input int br,
                              input int bd, input int bv);
      logic [7:0] exp_q[$];
      logic [7:0] sum;
      int         got_n;
      exp_q.push_back(8'h53);
      sum = 8'h00;
      for (int w = 0; w < int'(DEPTH); w++) begin
         for (int b = 0; b < 4; b++) begin
            logic [7:0] by;
            by = 8'(mem[w] >> (8 * b));
            exp_q.push_back(by);
            sum = sum + by;
         end
      end
      if (g == 0) exp_q.push_back(sum);
      got_n = cap_n[g] - bc;
      chk($sformatf("%s d%0d nbytes", tag, g), 32'(got_n), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_n; i++)
         chk($sformatf("%s d%0d byte%0d", tag, g, i), 32'(cap[g][bc + i]), 32'(exp_q[i]));
      chk($sformatf("%s d%0d nreads", tag, g), 32'(rd_n[g] - br), 32'(DEPTH));
      for (int i = 0; i < int'(DEPTH) && i < rd_n[g] - br; i++)
         chk($sformatf("%s d%0d rdaddr%0d", tag, g, i), 32'(rda[g][br + i]), 32'(i));
      chk($sformatf("%s d%0d ndone", tag, g), 32'(done_n[g] - bd), 32'd1);
      chk($sformatf("%s d%0d protocol", tag, g), 32'(viol[g] - bv), 32'd0);
      chk($sformatf("%s d%0d busy_after", tag, g), 32'(busy_w[g]), 32'd0);
   endtask

   task automatic run_frame(input string tag, input bit lat, input int hold,
                            input bit restart, input bit rnd);
      int bc[2], br[2], bd[2], bv[2];
      int t;
      for (int g = 0; g < 2; g++) begin
         bc[g] = cap_n[g]; br[g] = rd_n[g]; bd[g] = done_n[g]; bv[g] = viol[g];
      end
      if (hold > 0) ext_busy = 1'b1;
      start_v = 2'b11;
      @(negedge clk);
      start_v = 2'b00;
      if (lat) begin
         for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s d%0d busy_rise", tag, g), 32'(busy_w[g]), 32'd1);
            chk($sformatf("%s d%0d tx_early", tag, g), 32'(tx_start_w[g]), 32'd0);
         end
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s d%0d tx_lat2", tag, g), 32'(tx_start_w[g]), 32'd1);
            chk($sformatf("%s d%0d sync", tag, g), 32'(tx_data_w[g]), 32'h53);
         end
      end
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s d%0d tx_in_hold", tag, g), 32'(cap_n[g] - bc[g]), 32'd0);
            chk($sformatf("%s d%0d busy_in_hold", tag, g), 32'(busy_w[g]), 32'd1);
         end
         ext_busy = 1'b0;
      end
      t = 0;
      while ((busy_w[0] || busy_w[1]) && t < LIMIT) begin
         @(negedge clk);
         t++;
         start_v = restart ? ({done_w[1], done_w[0]} | ((t == 100) ? 2'b11 : 2'b00)) : 2'b00;
         if (rnd) ext_busy = ($urandom_range(0, 5) == 0);
      end
      start_v  = 2'b00;
      ext_busy = 1'b0;
      chk({tag, " timeout"}, 32'(t < LIMIT), 32'd1);
      repeat (8) @(negedge clk);
      for (int g = 0; g < 2; g++) check_frame(tag, g, bc[g], br[g], bd[g], bv[g]);
   endtask

   initial begin
      int b0, t;
      nRST = 1'b0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("rst d%0d busy", g), 32'(busy_w[g]), 32'd0);
         chk($sformatf("rst d%0d done", g), 32'(done_w[g]), 32'd0);
         chk($sformatf("rst d%0d rd_en", g), 32'(rd_en_w[g]), 32'd0);
         chk($sformatf("rst d%0d tx_start", g), 32'(tx_start_w[g]), 32'd0);
         chk($sformatf("rst d%0d addr", g), 32'(addr_w[g]), 32'd0);
         chk($sformatf("rst d%0d tx_data", g), 32'(tx_data_w[g]), 32'd0);
      end
      nRST = 1'b1;
      @(negedge clk);

      mem[0] = 32'h44332211; mem[1] = 32'h88776655;
      mem[2] = 32'hCCBBAA99; mem[3] = 32'h00FFEEDD;
      run_frame("basic", 1'b1, 0, 1'b0, 1'b0);
      chk("basic checksum", 32'(cap[0][cap_n[0] - 1]), 32'hF8);
      chk("basic nock last", 32'(cap[1][cap_n[1] - 1]), 32'h00);

      run_frame("hold", 1'b0, 50, 1'b0, 1'b0);
      run_frame("restart", 1'b0, 0, 1'b1, 1'b0);

      // Reset just after the sixth byte, then a full fresh frame
      b0 = cap_n[0];
      start_v = 2'b11;
      @(negedge clk);
      start_v = 2'b00;
      t = 0;
      while (cap_n[0] - b0 < 6 && t < LIMIT) begin
         @(negedge clk);
         t++;
      end
      chk("midrst reach6", 32'(t < LIMIT), 32'd1);
      nRST = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("midrst d%0d busy", g), 32'(busy_w[g]), 32'd0);
         chk($sformatf("midrst d%0d tx_start", g), 32'(tx_start_w[g]), 32'd0);
         chk($sformatf("midrst d%0d rd_en", g), 32'(rd_en_w[g]), 32'd0);
      end
      nRST = 1'b1;
      @(negedge clk);
      run_frame("after_rst", 1'b0, 0, 1'b0, 1'b0);

      for (int k = 0; k < 4; k++) begin
         for (int w = 0; w < int'(DEPTH); w++) mem[w] = $urandom;
         run_frame($sformatf("rnd%0d", k), 1'b0, (k == 1) ? 20 : 0, 1'b0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
